// File: rtl/issue_prf_mp.sv
// Multi-port physical register file for the issue stage: NUM_WR writes and NUM_RD
// combinational reads with write-first bypass, plus a ready scoreboard for rename/writeback.
module issue_prf_mp #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned PRF_DEPTH   = 64,
    parameter int unsigned ADDR_WIDTH  = $clog2(PRF_DEPTH),
    parameter int unsigned NUM_WR      = 2,
    parameter int unsigned NUM_RD      = 4,
    parameter int unsigned NUM_ALLOC   = 1,
    parameter bit          ZERO_REG_EN = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_WR-1:0]               wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]    wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]    wr_data,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]    rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]               rd_ready,
    input  logic [NUM_ALLOC-1:0]            alloc_en,
    input  logic [NUM_ALLOC*ADDR_WIDTH-1:0] alloc_addr,
    input  logic                            flush
);

    logic [DATA_WIDTH-1:0] mem_q [PRF_DEPTH];
    logic [PRF_DEPTH-1:0]  ready_q;
    logic [PRF_DEPTH-1:0]  ready_d;

    logic [ADDR_WIDTH-1:0] wa [NUM_WR];
    logic [DATA_WIDTH-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0]     wr_eff;
    logic [ADDR_WIDTH-1:0] aa [NUM_ALLOC];
    logic [NUM_ALLOC-1:0]  alloc_eff;

    // Writes and allocs that target p0 are dropped up front when it is hardwired.
    for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
        assign wa[i]     = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wd[i]     = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign wr_eff[i] = wr_en[i] && !(ZERO_REG_EN && (wa[i] == '0));
    end

    for (genvar k = 0; k < NUM_ALLOC; k++) begin : g_alloc
        assign aa[k]        = alloc_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign alloc_eff[k] = alloc_en[k] && !(ZERO_REG_EN && (aa[k] == '0));
    end

    // Applied lowest priority first so later assignments override: write < alloc < flush.
    always_comb begin
        ready_d = ready_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_eff[i]) ready_d[wa[i]] = 1'b1;
        end
        for (int k = 0; k < NUM_ALLOC; k++) begin
            if (alloc_eff[k]) ready_d[aa[k]] = 1'b0;
        end
        if (flush) ready_d = '1;
        if (ZERO_REG_EN) ready_d[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < PRF_DEPTH; p++) begin
                mem_q[p] <= '0;
            end
            ready_q <= '1;
        end else begin
            // Ascending port order: the highest colliding port lands last and wins.
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_eff[i]) mem_q[wa[i]] <= wd[i];
            end
            ready_q <= ready_d;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] data;
        logic                  rdy;

        assign ra = rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            data = mem_q[ra];
            rdy  = ready_q[ra];
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_eff[i] && (wa[i] == ra)) begin
                    data = wd[i];
                    rdy  = 1'b1;
                end
            end
            if (ZERO_REG_EN && (ra == '0)) begin
                data = '0;
                rdy  = 1'b1;
            end
        end

        assign rd_data[j*DATA_WIDTH +: DATA_WIDTH] = data;
        assign rd_ready[j]                         = rdy;
    end

endmodule

// File: tb/tb_issue_prf_mp.sv
// Randomised bench for issue_prf_mp: a per-register array model predicts every read port
// each cycle, plus directed scenarios for bypass, collisions, scoreboard, flush, p0 and reset.
module tb_issue_prf_mp;

    localparam int DW    = 64;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int NW    = 2;
    localparam int NR    = 4;
    localparam int NA    = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NW-1:0]        wr_en;
    logic [NW*AW-1:0]     wr_addr;
    logic [NW*DW-1:0]     wr_data;
    logic [NR*AW-1:0]     rd_addr;
    logic [NR*DW-1:0]     rd_data;
    logic [NR-1:0]        rd_ready;
    logic [NA-1:0]        alloc_en;
    logic [NA*AW-1:0]     alloc_addr;
    logic                 flush;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_mem [DEPTH];
    logic          m_rdy [DEPTH];

    issue_prf_mp dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r] = '0;
            m_rdy[r] = 1'b1;
        end
    endfunction

    // Architectural view of a read: p0 is zero, otherwise newest same-cycle write, else state.
    function automatic void expect_read(input int a, output logic [DW-1:0] d, output logic r);
        d = m_mem[a];
        r = m_rdy[a];
        if (a == 0) begin
            d = '0;
            r = 1'b1;
            return;
        end
        for (int i = 0; i < NW; i++) begin
            if (wr_en[i] && int'(wr_addr[i*AW +: AW]) == a) begin
                d = wr_data[i*DW +: DW];
                r = 1'b1;
            end
        end
    endfunction

    // Per-register outcome of one clock edge.
    function automatic void model_edge();
        for (int r = 1; r < DEPTH; r++) begin
            bit hit_w = 0;
            bit hit_a = 0;
            for (int i = 0; i < NW; i++) begin
                if (wr_en[i] && int'(wr_addr[i*AW +: AW]) == r) begin
                    m_mem[r] = wr_data[i*DW +: DW];
                    hit_w    = 1;
                end
            end
            for (int k = 0; k < NA; k++) begin
                if (alloc_en[k] && int'(alloc_addr[k*AW +: AW]) == r) hit_a = 1;
            end
            if (flush)      m_rdy[r] = 1'b1;
            else if (hit_a) m_rdy[r] = 1'b0;
            else if (hit_w) m_rdy[r] = 1'b1;
        end
    endfunction

    task automatic check_reads(input string tag);
        logic [DW-1:0] d;
        logic          r;
        for (int j = 0; j < NR; j++) begin
            expect_read(int'(rd_addr[j*AW +: AW]), d, r);
            check({tag, "_data"}, rd_data[j*DW +: DW], d);
            check({tag, "_rdy"}, {63'b0, rd_ready[j]}, {63'b0, r});
        end
    endtask

    task automatic idle();
        wr_en    = '0;
        alloc_en = '0;
        flush    = 1'b0;
    endtask

    task automatic set_wr(input int i, input int a, input logic [DW-1:0] d);
        wr_en[i]            = 1'b1;
        wr_addr[i*AW +: AW] = AW'(a);
        wr_data[i*DW +: DW] = d;
    endtask

    task automatic set_rd(input int j, input int a);
        rd_addr[j*AW +: AW] = AW'(a);
    endtask

    task automatic set_alloc(input int k, input int a);
        alloc_en[k]            = 1'b1;
        alloc_addr[k*AW +: AW] = AW'(a);
    endtask

    // Called with inputs already driven: check comb outputs, take an edge, advance the model.
    task automatic cycle(input string tag);
        #1;
        check_reads(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic sweep(input string tag);
        idle();
        for (int a = 0; a < DEPTH; a += NR) begin
            for (int j = 0; j < NR; j++) set_rd(j, a + j);
            #1;
            check_reads(tag);
        end
    endtask

    initial begin
        reset      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_addr    = '0;
        alloc_addr = '0;
        idle();
        model_clear();
        #12 reset = 1'b1;
        @(posedge clk);
        #1;
        sweep("reset");

        // Write with same-cycle bypass, then read from storage.
        idle();
        set_wr(0, 5, 64'hDEAD_BEEF);
        set_rd(0, 5);
        #1 check("byp5", rd_data[DW-1:0], 64'hDEAD_BEEF);
        cycle("wr5");
        idle();
        #1 check("stored5", rd_data[DW-1:0], 64'hDEAD_BEEF);

        // Two ports hit one address: highest port wins.
        set_wr(0, 9, 64'h11);
        set_wr(1, 9, 64'h22);
        set_rd(0, 9);
        #1 check("coll_byp", rd_data[DW-1:0], 64'h22);
        cycle("coll");
        idle();
        #1 check("coll_stored", rd_data[DW-1:0], 64'h22);

        // Scoreboard: alloc clears, writeback sets (bypassed), alloc beats write.
        set_alloc(0, 12);
        set_rd(0, 12);
        cycle("alloc12");
        idle();
        #1 check("alloc12_rdy", {63'b0, rd_ready[0]}, 64'd0);
        set_wr(0, 12, 64'h1234);
        #1 check("wb12_byp_rdy", {63'b0, rd_ready[0]}, 64'd1);
        cycle("wb12");
        idle();
        #1 check("wb12_rdy", {63'b0, rd_ready[0]}, 64'd1);
        set_alloc(0, 12);
        set_wr(1, 12, 64'h5678);
        cycle("alloc_wr12");
        idle();
        #1 check("alloc_wr12_rdy", {63'b0, rd_ready[0]}, 64'd0);
        check("alloc_wr12_data", rd_data[DW-1:0], 64'h5678);

        // Flush overrides a same-cycle alloc.
        foreach (m_rdy[r]) if (r == 3 || r == 4 || r == 7) begin
            idle();
            set_alloc(0, r);
            cycle("pre_flush");
        end
        idle();
        set_rd(0, 3);
        set_rd(1, 4);
        set_rd(2, 7);
        set_rd(3, 8);
        #1 check("pre_flush_rdy", {60'b0, rd_ready}, 64'h8);
        flush = 1'b1;
        set_alloc(0, 8);
        cycle("flush");
        idle();
        #1 check("post_flush_rdy", {60'b0, rd_ready}, 64'hF);

        // Hardwired p0.
        set_wr(1, 0, 64'hFF);
        set_alloc(0, 0);
        set_rd(0, 0);
        #1 check("p0_byp", rd_data[DW-1:0], 64'd0);
        check("p0_byp_rdy", {63'b0, rd_ready[0]}, 64'd1);
        cycle("p0_wr");
        idle();
        #1 check("p0_stored", rd_data[DW-1:0], 64'd0);

        // Random traffic over a small address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < NW; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_wr(i, $urandom_range(0, 15), {$urandom, $urandom});
            end
            for (int k = 0; k < NA; k++) begin
                if ($urandom_range(0, 2) == 0) set_alloc(k, $urandom_range(0, 15));
            end
            flush = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < NR; j++) set_rd(j, $urandom_range(0, 15));
            cycle("rand");
        end

        // Asynchronous reset between edges while writes are pending.
        idle();
        set_wr(0, 20, 64'hCAFE);
        set_alloc(0, 21);
        cycle("pre_rst");
        set_wr(1, 22, 64'hBEEF);
        #2 reset = 1'b0;
        model_clear();
        #1;
        sweep("midrst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 50; n++) begin
            idle();
            for (int i = 0; i < NW; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_wr(i, $urandom_range(0, 31), {$urandom, $urandom});
            end
            if ($urandom_range(0, 2) == 0) set_alloc(0, $urandom_range(0, 31));
            for (int j = 0; j < NR; j++) set_rd(j, $urandom_range(0, 31));
            cycle("post_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
